// File: rtl/count_disp_pkg.sv
// Shared constants, scan states and the hex-to-seven-segment decoder for count_display_scan.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package count_disp_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         HIST_DEPTH = 4;

    typedef enum logic [1:0] {
        SCAN_D0,
        SCAN_D1,
        SCAN_D2,
        SCAN_D3
    } scan_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_value);
        logic [6:0] w_seg;
        case (i_value)
            4'h0:    w_seg = 7'h40;
            4'h1:    w_seg = 7'h79;
            4'h2:    w_seg = 7'h24;
            4'h3:    w_seg = 7'h30;
            4'h4:    w_seg = 7'h19;
            4'h5:    w_seg = 7'h12;
            4'h6:    w_seg = 7'h02;
            4'h7:    w_seg = 7'h78;
            4'h8:    w_seg = 7'h00;
            4'h9:    w_seg = 7'h10;
            4'hA:    w_seg = 7'h08;
            4'hB:    w_seg = 7'h03;
            4'hC:    w_seg = 7'h46;
            4'hD:    w_seg = 7'h21;
            4'hE:    w_seg = 7'h06;
            4'hF:    w_seg = 7'h0E;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/count_display_scan_seg_refresh_div.sv
// Refresh divider for the multiplexed display: a REFRESH_DIV-cycle slot timer
// and a four-state digit scan machine that advances once per slot.
module seg_refresh_div
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_tick,
    output logic [1:0] o_scan
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    scan_state_e      r_state;
    scan_state_e      w_next_state;

    assign w_tick = (r_div == DIV_W'(REFRESH_DIV - 1));
    assign o_tick = w_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SCAN_D0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_tick) begin
            case (r_state)
                SCAN_D0: w_next_state = SCAN_D1;
                SCAN_D1: w_next_state = SCAN_D2;
                SCAN_D2: w_next_state = SCAN_D3;
                SCAN_D3: w_next_state = SCAN_D0;
                default: w_next_state = SCAN_D0;
            endcase
        end
    end

    always_comb begin
        o_scan = 2'd0;
        case (r_state)
            SCAN_D0: o_scan = 2'd0;
            SCAN_D1: o_scan = 2'd1;
            SCAN_D2: o_scan = 2'd2;
            SCAN_D3: o_scan = 2'd3;
            default: o_scan = 2'd0;
        endcase
    end

endmodule

// File: rtl/count_display_scan.sv
// Shows the last four distinct counter values on a 4-digit common-anode display,
// newest on digit 0, with a sticky wrap flag on digit 0's decimal point.
// Optional macro COUNT_DISP_BLINK_EN blinks digit 0 for a few frames after each new value.
module count_display_scan
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    logic [3:0] r_cur;
    logic       r_cur_valid;
    logic [3:0] r_last;
    logic [3:0] r_hist [0:HIST_DEPTH-1];
    logic [2:0] r_hist_cnt;
    logic       r_seeded;
    logic       r_wrap_seen;

    logic       w_tick;
    logic [1:0] w_scan;
    logic       w_push;
    logic       w_wrap;
    logic       w_suppress;
    logic       w_blank;
    logic [3:0] w_an_onehot;

    seg_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh (
        .i_clk   (clk),
        .i_rst_n (rst),
        .o_tick  (w_tick),
        .o_scan  (w_scan)
    );

    // r_cur_valid keeps the cleared r_cur from being pushed as if it were a real sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur       <= 4'h0;
            r_cur_valid <= 1'b0;
        end else begin
            r_cur       <= {a3, a2, a1, a0};
            r_cur_valid <= 1'b1;
        end
    end

    assign w_push = r_cur_valid && (!r_seeded || (r_cur != r_last));
    assign w_wrap = w_push && r_seeded && (r_last == 4'hF) && (r_cur == 4'h0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= 4'h0;
            end
            r_last      <= 4'h0;
            r_hist_cnt  <= 3'd0;
            r_seeded    <= 1'b0;
            r_wrap_seen <= 1'b0;
        end else begin
            if (w_push) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                    r_hist[i] <= r_hist[i-1];
                end
                r_hist[0] <= r_cur;
                r_last    <= r_cur;
                r_seeded  <= 1'b1;
                if (r_hist_cnt != 3'(HIST_DEPTH)) begin
                    r_hist_cnt <= r_hist_cnt + 3'd1;
                end
            end
            if (w_wrap) begin
                r_wrap_seen <= 1'b1;
            end
        end
    end

`ifdef COUNT_DISP_BLINK_EN
    logic [2:0] r_blink;
    logic       w_frame_end;

    assign w_frame_end = w_tick && (w_scan == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink <= 3'd0;
        end else if (w_push) begin
            r_blink <= 3'd7;
        end else if (w_frame_end && (r_blink != 3'd0)) begin
            r_blink <= r_blink - 3'd1;
        end
    end

    assign w_suppress = (w_scan == 2'd0) && (r_blink != 3'd0) && r_blink[0];
`else
    assign w_suppress = 1'b0;
`endif

    assign w_blank     = ({1'b0, w_scan} >= r_hist_cnt) || w_suppress;
    assign w_an_onehot = 4'b0001 << w_scan;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= w_blank ? SEG_BLANK : hex_to_seg(r_hist[w_scan]);
            an  <= w_blank ? 4'hF : ~w_an_onehot;
            dp  <= !((w_scan == 2'd0) && r_wrap_seen && !w_blank);
        end
    end

endmodule
